// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
//   state_t : transaction sequencer states
//   owner_t : requester that owns the current memory transaction
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed-priority grant with a fetch-starvation escape.
//   if_req, dm_req     : pending requests
//   wait_cnt           : data grants issued while the current fetch waited
//   grant_if, grant_dm : one-hot (or zero) grant, combinational
module mem_arb_prio #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic             if_req,
    input  logic             dm_req,
    input  logic [CNT_W-1:0] wait_cnt,
    output logic             grant_if,
    output logic             grant_dm
);

    // Data wins unless a fetch has already been overtaken MAX_WAIT times.
    always_comb begin
        grant_dm = dm_req & (~if_req | (wait_cnt < CNT_W'(MAX_WAIT)));
        grant_if = if_req & ~grant_dm;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port variable-latency memory between fetch and data
// requesters, one outstanding transaction at a time.
//   clk, reset                         : clock, async active-high reset
//   if_req/if_addr -> if_rdata/if_done : fetch requester
//   dm_req/dm_we/dm_addr/dm_wdata
//                  -> dm_rdata/dm_done : data requester
//   mem_req/mem_we/mem_addr/mem_wdata
//                  <- mem_rdata/mem_ack: memory side
//   stall_if, stall_dm                 : combinational hazard-unit stalls
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_done,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             dm_done,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             stall_if,
    output logic             stall_dm
);

    state_t             state, state_nxt;
    owner_t             owner, owner_nxt;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic               grant_if, grant_dm;
    logic               mem_req_nxt, mem_we_nxt;
    logic [WIDTH-1:0]   mem_addr_nxt, mem_wdata_nxt;
    logic [WIDTH-1:0]   if_rdata_nxt, dm_rdata_nxt;
    logic               if_done_nxt, dm_done_nxt;

    mem_arb_prio #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_prio (
        .if_req   (if_req),
        .dm_req   (dm_req),
        .wait_cnt (wait_cnt),
        .grant_if (grant_if),
        .grant_dm (grant_dm)
    );

    // Stalls release in the done cycle so the pipeline advances with the data.
    assign stall_if = if_req & ~if_done;
    assign stall_dm = dm_req & ~dm_done;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        wait_cnt_nxt  = wait_cnt;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        if_rdata_nxt  = if_rdata;
        dm_rdata_nxt  = dm_rdata;
        if_done_nxt   = 1'b0;
        dm_done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                // Counter only tracks overtakes of a fetch that is still waiting.
                if (!if_req || grant_if) begin
                    wait_cnt_nxt = '0;
                end else if (grant_dm && (wait_cnt < CNT_W'(MAX_WAIT))) begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
                if (grant_dm || grant_if) begin
                    owner_nxt     = grant_dm ? OWN_DM : OWN_IF;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = grant_dm & dm_we;
                    mem_addr_nxt  = grant_dm ? dm_addr : if_addr;
                    mem_wdata_nxt = grant_dm ? dm_wdata : '0;
                    state_nxt     = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = RESP;
                    if (owner == OWN_DM) begin
                        dm_done_nxt = 1'b1;
                        if (!mem_we) dm_rdata_nxt = mem_rdata;
                    end else begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            if_rdata  <= if_rdata_nxt;
            dm_rdata  <= dm_rdata_nxt;
            if_done   <= if_done_nxt;
            dm_done   <= dm_done_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter. The bench plays both
// requesters and the memory, and predicts every output from a
// transaction-level model: grant order, memory phase length, done timing and
// returned data.
module tb_mem_port_arbiter;

    localparam int unsigned W  = 32;
    localparam int unsigned MW = 4;
    localparam int unsigned CW = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         if_req, dm_req, dm_we, mem_ack;
    logic [W-1:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [W-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic         if_done, dm_done, mem_req, mem_we, stall_if, stall_dm;

    mem_port_arbiter #(
        .WIDTH    (W),
        .MAX_WAIT (MW),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_if  (stall_if),
        .stall_dm  (stall_dm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference memory contents (16 words).
    logic [31:0] mem_arr [16];

    // Transaction-level model state.
    int          cyc;
    bit          busy;          // a transaction is in flight
    bit          m_dm;          // current transaction belongs to data
    bit          m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    int          m_start, m_ack, m_done;
    int          overtakes;     // data grants while the current fetch waited
    logic [31:0] exp_if_rdata, exp_dm_rdata;
    bit          if_pend, dm_pend, if_rel, dm_rel;
    int          n_if_grants, n_dm_grants;

    task automatic model_reset();
        busy = 0; overtakes = 0;
        exp_if_rdata = '0; exp_dm_rdata = '0;
        if_pend = 0; dm_pend = 0; if_rel = 0; dm_rel = 0;
        if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
    endtask

    // One clock cycle: drive inputs just after the edge, check at the falling edge.
    task automatic step_cycle(input int p);
        bit          can_grant, exp_mem_req, exp_if_done, exp_dm_done;
        int          lat;
        @(posedge clk);
        #1;
        cyc++;

        exp_mem_req = busy && (cyc >= m_start) && (cyc <= m_ack);
        exp_if_done = busy && (cyc == m_done) && !m_dm;
        exp_dm_done = busy && (cyc == m_done) && m_dm;
        can_grant   = !busy;

        // Requesters drop their request the cycle after their done.
        if (if_rel) begin if_pend = 0; if_req = 0; if_rel = 0; end
        if (dm_rel) begin dm_pend = 0; dm_req = 0; dm_rel = 0; end
        if (!if_pend && ($urandom_range(0, 99) < p)) begin
            if_pend = 1; if_req = 1;
            if_addr = 32'($urandom_range(0, 15)) << 2;
        end
        if (!dm_pend && ($urandom_range(0, 99) < p)) begin
            dm_pend  = 1; dm_req = 1;
            dm_we    = ($urandom_range(0, 2) == 0);
            dm_addr  = 32'($urandom_range(0, 15)) << 2;
            dm_wdata = $urandom;
        end

        if (exp_if_done) begin exp_if_rdata = m_rdata; if_rel = 1; end
        if (exp_dm_done) begin
            if (!m_we) exp_dm_rdata = m_rdata;
            dm_rel = 1;
        end
        if (busy && cyc == m_done) busy = 0;

        // Grant: data first, but a waiting fetch may be overtaken only MW times.
        if (can_grant && (if_req || dm_req)) begin
            if (dm_req && (!if_req || overtakes < MW)) begin
                m_dm = 1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
                overtakes = if_req ? overtakes + 1 : 0;
                n_dm_grants++;
            end else begin
                m_dm = 0; m_we = 0; m_addr = if_addr; m_wdata = '0;
                overtakes = 0;
                n_if_grants++;
            end
            m_rdata = mem_arr[m_addr[5:2]];
            if (m_we) mem_arr[m_addr[5:2]] = m_wdata;
            lat     = $urandom_range(1, 4);
            busy    = 1;
            m_start = cyc + 1;
            m_ack   = cyc + lat;
            m_done  = cyc + lat + 1;
        end else if (can_grant && !if_req) begin
            overtakes = 0;
        end

        // Memory: ack only on the chosen cycle of the memory phase; random
        // spurious acks outside it must be ignored.
        if (busy && cyc == m_ack) begin
            mem_ack   = 1;
            mem_rdata = m_we ? $urandom : m_rdata;
        end else if (busy && cyc >= m_start && cyc < m_ack) begin
            mem_ack   = 0;
            mem_rdata = $urandom;
        end else begin
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
        end

        @(negedge clk);
        check_val("mem_req", 32'(mem_req), 32'(exp_mem_req));
        check_val("if_done", 32'(if_done), 32'(exp_if_done));
        check_val("dm_done", 32'(dm_done), 32'(exp_dm_done));
        check_val("if_rdata", if_rdata, exp_if_rdata);
        check_val("dm_rdata", dm_rdata, exp_dm_rdata);
        check_val("stall_if", 32'(stall_if), 32'(if_req & ~exp_if_done));
        check_val("stall_dm", 32'(stall_dm), 32'(dm_req & ~exp_dm_done));
        if (exp_mem_req) begin
            check_val("mem_addr", mem_addr, m_addr);
            check_val("mem_we", 32'(mem_we), 32'(m_we));
            if (m_we) check_val("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    task automatic run(input int n, input int p);
        for (int i = 0; i < n; i++) step_cycle(p);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;
        cyc = 0; n_if_grants = 0; n_dm_grants = 0;
        m_start = 0; m_ack = 0; m_done = 0; m_dm = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        model_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'd0);
        check_val("rst_if_done", 32'(if_done), 32'd0);
        check_val("rst_dm_done", 32'(dm_done), 32'd0);
        check_val("rst_if_rdata", if_rdata, 32'd0);
        check_val("rst_dm_rdata", dm_rdata, 32'd0);
        reset = 0;

        run(300, 30);
        run(300, 100);   // both requesters saturated: starvation escape
        run(300, 60);
        run(20, 0);      // drain

        // Reset while a fetch is waiting for its ack.
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h40; dm_req = 0; mem_ack = 0;
        @(posedge clk); #1;
        mem_ack = 0;
        check_val("busy_mem_req", 32'(mem_req), 32'd1);
        check_val("busy_mem_addr", mem_addr, 32'h40);
        #2 reset = 1;
        #1;
        check_val("arst_mem_req", 32'(mem_req), 32'd0);
        check_val("arst_if_done", 32'(if_done), 32'd0);
        @(posedge clk); #1;
        check_val("arst_if_done2", 32'(if_done), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 0;

        run(300, 100);
        run(200, 20);
        run(20, 0);

        check_val("saw_if_grants", 32'(n_if_grants > 50), 32'd1);
        check_val("saw_dm_grants", 32'(n_dm_grants > 50), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch requester and its data-memory (MEM stage) requester. It sequences one outstanding memory transaction at a time. It returns read data and a one-cycle done pulse to the winning requester, and drives per-requester stall lines into the hazard unit. Data accesses have priority, and a starvation counter guarantees that fetch makes forward progress.

Parameters:
WIDTH, 32, data and address width in bits
MAX_WAIT, 4, consecutive data grants allowed while a fetch waits; 0 gives fetch absolute priority
CNT_W, 3, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held with if_addr stable until if_done
if_addr  in  WIDTH  fetch address
if_rdata  out  WIDTH  fetch read data; valid while if_done is high, held otherwise
if_done  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_done
dm_we  in  1  1 = write, 0 = read
dm_addr  in  WIDTH  data address
dm_wdata  in  WIDTH  write data
dm_rdata  out  WIDTH  data read data; valid with dm_done on reads
dm_done  out  1  one-cycle completion pulse for data
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  WIDTH  memory address
mem_wdata  out  WIDTH  memory write data
mem_rdata  in  WIDTH  memory read data; valid in the cycle mem_ack is high
mem_ack  in  1  memory completion; may be high in the first mem_req cycle
stall_if  out  1  if_req & ~if_done (combinational)
stall_dm  out  1  dm_req & ~dm_done (combinational)

Behaviour:
- Reset: state IDLE, wait_cnt 0; all registered outputs (mem_*, if_rdata, dm_rdata, if_done, dm_done) 0.
- FSM states:
  - IDLE: arbitrate; if a winner exists, latch owner, addr, we and wdata into the mem_* registers and go to BUSY.
  - BUSY: mem_req=1 with all mem_* fields stable. When mem_ack=1, capture mem_rdata into the owner's rdata register (reads only) and go to RESP.
  - RESP: the owner's done is 1 for exactly one cycle; mem_req=0; go to IDLE.
- Arbitration in IDLE:
  - dm wins if dm_req & (~if_req | wait_cnt < MAX_WAIT).
  - Otherwise if wins if if_req.
  - Otherwise no grant; stay in IDLE.
- wait_cnt:
  - +1 when dm is granted while if_req=1.
  - Cleared when if is granted, or on any IDLE cycle with if_req=0.
  - Saturates at MAX_WAIT.
- Minimum latency: request seen in IDLE at cycle 0 → mem_req in cycle 1 → ack in cycle 1 → done in cycle 2 → IDLE in cycle 3.
- Writes: dm_rdata is unchanged and mem_rdata is ignored; dm_done still pulses.
- If if_rdata/dm_rdata is not the owner's, it holds its previous value.
- mem_ack in IDLE or RESP is ignored.
- A requester that drops req during BUSY does not abort the transaction; done still pulses and the requester ignores it.
- Reset asserted mid-BUSY: the transaction is abandoned; mem_req drops immediately (asynchronous); no done pulse.
- Simultaneous if_req and dm_req in IDLE: exactly one grant, per the rule above; never both.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUSY, RESP}
  - owner enum {OWN_IF, OWN_DM}
- One sub-module, mem_arb_prio, is natural: it is combinational and takes if_req, dm_req and wait_cnt, returning grant_if/grant_dm.
- The FSM, counter and data registers live in the top level.

Test Plan:
1. Single fetch: if_req=1, if_addr=0x10; mem_ack=1 in the first mem_req cycle; mem_rdata=0xE3A01005 → mem_req=1/mem_we=0/mem_addr=0x10 in cycle 1, if_done=1 and if_rdata=0xE3A01005 in cycle 2, stall_if high in cycles 0–1 only.
2. Collision: if_req (addr 0x20) and dm read (addr 0x200) in the same cycle, MAX_WAIT=4 → first mem_addr=0x200, dm_done first; the next transaction is mem_addr=0x20 with if_done; wait_cnt returns to 0.
3. Starvation: dm_req held continuously, with new addresses 0x300, 0x304, … after each dm_done, and if_req held → exactly 4 dm grants, then the 5th grant goes to fetch, then dm resumes.
4. Write with delay: dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF; ack arrives in the 3rd mem_req cycle → mem_req held for 3 cycles with addr/wdata/we stable; a single dm_done; dm_rdata unchanged from its prior value.
5. Reset during BUSY (before ack) → mem_req=0 immediately, no done pulse, wait_cnt=0; a subsequent fetch completes normally.
6. Spurious mem_ack=1 while IDLE with mem_rdata=0xFFFFFFFF → no done pulse and if_rdata/dm_rdata unchanged.
